// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encoding, FSM state encoding and HI/LO width for the MDU front end
package mdu_pkg;
  localparam int HILO_W = 64;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MADDU = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;
  localparam logic [2:0] OP_MSUBU = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_ACC = 2'd2} state_e;
  // accumulate class is op[2:1] of the multiply-class ops
  typedef enum logic [1:0] {C_SET = 2'd0, C_ADD = 2'd1, C_SUB = 2'd2} acc_e;
endpackage

// File: rtl/multi.sv
// multi: combinational radix-2 Booth array multiplier, operands taken as two's complement
//   a, b : IN_DATA_WIDTH-bit operands
//   p    : OUT_DATA_WIDTH-bit product
module multi #(
  parameter int IN_DATA_WIDTH  = 33,
  parameter int OUT_DATA_WIDTH = 66
) (
  input  logic [IN_DATA_WIDTH-1:0]  a,
  input  logic [IN_DATA_WIDTH-1:0]  b,
  output logic [OUT_DATA_WIDTH-1:0] p
);
  logic [OUT_DATA_WIDTH-1:0] a_ext;
  logic [IN_DATA_WIDTH:0]    b_ext;
  assign a_ext = {{(OUT_DATA_WIDTH-IN_DATA_WIDTH){a[IN_DATA_WIDTH-1]}}, a};
  assign b_ext = {b, 1'b0};
  // pair (b[i], b[i-1]): 01 adds a<<i, 10 subtracts a<<i
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_DATA_WIDTH; i++) begin
      if ({b_ext[i+1], b_ext[i]} == 2'b01) p = p + (a_ext << i);
      else if ({b_ext[i+1], b_ext[i]} == 2'b10) p = p - (a_ext << i);
    end
  end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: MIPS HI/LO multiply/accumulate front end around the multicycle multi path
//   clk, rst_n      : clock, async active-low reset
//   in_valid/ready  : request handshake (ready = IDLE)
//   op, rs/rt_data  : operation and operands (rs is the MTHI/MTLO source)
//   flush           : cancel in-flight op / block acceptance
//   busy, done      : op in flight / one-cycle HI/LO write pulse
//   hi, lo          : architectural registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_e state_q, state_d;
  acc_e cls_q, cls_d;
  logic [3:0] cnt_q, cnt_d;
  logic [32:0] a_q, a_d, b_q, b_d;
  logic [HILO_W-1:0] prod_q, prod_d, hilo_new;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic done_q, done_d;
  logic [65:0] p;
  logic unused_p;
  logic accept;
  multi #(.IN_DATA_WIDTH(33), .OUT_DATA_WIDTH(66)) u_multi (.a(a_q), .b(b_q), .p(p));
  // bits [63:0] are exact for signed and unsigned 32x32; the top two are redundant
  assign unused_p = ^p[65:64];
  assign accept   = in_valid & in_ready & ~flush;
  assign in_ready = state_q == S_IDLE;
  assign busy     = state_q != S_IDLE;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  always_comb
    hilo_new = cls_q == C_ADD ? {hi_q, lo_q} + prod_q :
               cls_q == C_SUB ? {hi_q, lo_q} - prod_q : prod_q;
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (op == OP_MTHI) hi_d = rs_data;
        else if (op == OP_MTLO) lo_d = rs_data;
        else begin
          // op[0] selects the unsigned variant: zero- instead of sign-extend
          a_d     = {~op[0] & rs_data[31], rs_data};
          b_d     = {~op[0] & rt_data[31], rt_data};
          cls_d   = acc_e'(op[2:1]);
          cnt_d   = 4'(MUL_CYCLES - 1);
          state_d = S_MUL;
        end
      end
      S_MUL: if (flush) state_d = S_IDLE;
        else if (cnt_q == 4'd0) begin
          prod_d  = p[HILO_W-1:0];
          state_d = S_ACC;
        end else cnt_d = cnt_q - 4'd1;
      S_ACC: if (flush) state_d = S_IDLE;
        else begin
          {hi_d, lo_d} = hilo_new;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_SET;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized and directed checks of mdu_hilo against a 64-bit arithmetic HI/LO model
module tb_mdu_hilo;
  localparam int MC = 2;
  logic clk = 1'b0;
  logic rst_n, in_valid, flush;
  logic [2:0] op;
  logic [31:0] rs_data, rt_data;
  logic in_ready, busy, done;
  logic [31:0] hi, lo;
  logic [63:0] exp_hl;
  int n_cmp = 0;
  int n_err = 0;

  mdu_hilo #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] cur);
    logic [63:0] prd;
    prd = o[0] ? {32'b0, a} * {32'b0, b}
               : 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    case (o[2:1])
      2'b00:   return prd;
      2'b01:   return cur + prd;
      2'b10:   return cur - prd;
      default: return o[0] ? {cur[63:32], a} : {a, cur[31:0]};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int k;
    @(negedge clk);
    in_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    in_valid = 1'b0;
    exp_hl = ref_op(o, a, b, exp_hl);
    if (o[2:1] == 2'b11) begin
      n_cmp++;
      if ({hi, lo} !== exp_hl || done !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mthilo op=%0d: hilo=%h done=%b rdy=%b expected hilo=%h done=0 rdy=1", o, {hi, lo}, done, in_ready, exp_hl);
      end
    end else begin
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL accept_busy op=%0d: busy=%b rdy=%b expected busy=1 rdy=0", o, busy, in_ready);
      end
      k = 0;
      while (done !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      n_cmp++;
      if (k != MC + 1) begin
        n_err++;
        $display("FAIL latency op=%0d: %0d cycles expected %0d", o, k, MC + 1);
      end
      n_cmp++;
      if ({hi, lo} !== exp_hl || busy !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL result op=%0d a=%h b=%h: hilo=%h busy=%b rdy=%b expected hilo=%h busy=0 rdy=1", o, a, b, {hi, lo}, busy, in_ready, exp_hl);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse op=%0d: done=%b expected 0", o, done);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    #12;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b rdy=%b expected 0 0 0 0 1", hi, lo, busy, done, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hl = '0;
  endtask

  task automatic test_directed;
    run_op(3'b000, 32'hFFFF_FFFF, 32'h2);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_err++;
      $display("FAIL mult_neg: hilo=%h expected ffffffff_fffffffe", {hi, lo});
    end
    run_op(3'b001, 32'hFFFF_FFFF, 32'h2);
    n_cmp++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
      n_err++;
      $display("FAIL multu: hilo=%h expected 00000001_fffffffe", {hi, lo});
    end
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000);
    n_cmp++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      n_err++;
      $display("FAIL mult_min: hilo=%h expected 40000000_00000000", {hi, lo});
    end
    run_op(3'b111, 32'd5, 32'd0);
    run_op(3'b110, 32'd0, 32'd0);
    run_op(3'b010, 32'd3, 32'd4);
    n_cmp++;
    if ({hi, lo} !== 64'h11) begin
      n_err++;
      $display("FAIL madd: hilo=%h expected 11", {hi, lo});
    end
    run_op(3'b101, 32'h11, 32'd1);
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_err++;
      $display("FAIL msubu: hilo=%h expected 0", {hi, lo});
    end
    run_op(3'b100, 32'd1, 32'd1);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL msub_wrap: hilo=%h expected ffffffff_ffffffff", {hi, lo});
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 7 == 0) a = 32'h8000_0000;
      if (i % 5 == 0) b = 32'hFFFF_FFFF;
      run_op(3'($urandom_range(0, 7)), a, b);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; rs_data = a; rt_data = b;
    @(negedge clk);
    op = 3'b010; rs_data = c; rt_data = d;
    exp_hl = ref_op(3'b000, a, b, exp_hl);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != MC + 1 || {hi, lo} !== exp_hl || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: k=%0d hilo=%h rdy=%b expected k=%0d hilo=%h rdy=1", k, {hi, lo}, in_ready, MC + 1, exp_hl);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_hl = ref_op(3'b010, c, d, exp_hl);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != MC + 1 || {hi, lo} !== exp_hl) begin
      n_err++;
      $display("FAIL b2b_second: k=%0d hilo=%h expected k=%0d hilo=%h", k, {hi, lo}, MC + 1, exp_hl);
    end
    @(negedge clk);
  endtask

  task automatic test_flush(input int dly);
    int seen;
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (dly) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || {hi, lo} !== exp_hl) begin
      n_err++;
      $display("FAIL flush_%0d: busy=%b rdy=%b hilo=%h expected 0 1 %h", dly, busy, in_ready, {hi, lo}, exp_hl);
    end
    seen = 0;
    repeat (5) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0 || {hi, lo} !== exp_hl) begin
      n_err++;
      $display("FAIL flush_nodone_%0d: done_pulses=%0d hilo=%h expected 0 %h", dly, seen, {hi, lo}, exp_hl);
    end
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    in_valid = 1'b1; op = 3'b110; rs_data = ~hi; flush = 1'b1;
    @(negedge clk);
    op = 3'b000;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if ({hi, lo} !== exp_hl || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: hilo=%h busy=%b expected %h 0", {hi, lo}, busy, exp_hl);
    end
  endtask

  task automatic test_reset_mid;
    run_op(3'b110, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_hl = '0;
    n_cmp++;
    if ({hi, lo} !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: hilo=%h busy=%b rdy=%b done=%b expected 0 0 1 0", {hi, lo}, busy, in_ready, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd7, 32'd6);
    n_cmp++;
    if (lo !== 32'h2A || hi !== 32'd0) begin
      n_err++;
      $display("FAIL after_reset: hi=%h lo=%h expected 0 2a", hi, lo);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    for (int d = 0; d <= MC; d++) test_flush(d);
    test_flush_idle;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
